// File: rtl/hazard_if.sv
// Hazard-unit bus: ID-stage decode fields and MEM-stage flags in, hazard and forwarding controls out.
// The decode/control path is the master; the hazard unit is the slave.
interface hazard_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             ID_Valid;
  logic [REG_W-1:0] ID_rs;
  logic [REG_W-1:0] ID_rt;
  logic             ID_UsesRs;
  logic             ID_UsesRt;
  logic [REG_W-1:0] ID_WriteReg;
  logic             ID_RegWre;
  logic             ID_MemRead;
  logic [1:0]       ID_BranchType;
  logic             MEM_Zero;
  logic             MEM_Sign;
  logic             Branch;
  logic             ControlSrc;
  logic             Stall;
  logic [1:0]       ForwardA;
  logic [1:0]       ForwardB;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;

  modport master (
    output ID_Valid, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_WriteReg,
           ID_RegWre, ID_MemRead, ID_BranchType, MEM_Zero, MEM_Sign,
    input  Branch, ControlSrc, Stall, ForwardA, ForwardB, StallCount, FlushCount
  );

  modport slave (
    input  ID_Valid, ID_rs, ID_rt, ID_UsesRs, ID_UsesRt, ID_WriteReg,
           ID_RegWre, ID_MemRead, ID_BranchType, MEM_Zero, MEM_Sign,
    output Branch, ControlSrc, Stall, ForwardA, ForwardB, StallCount, FlushCount
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: branch resolution in MEM, load-use bubble/stall, EX operand forwarding,
// backed by a private EX/MEM/WB scoreboard that advances with the pipeline registers.
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic   CLK,
  input  logic   Reset,
  hazard_if.slave hz
);

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic             ur;
    logic             ut;
    logic [REG_W-1:0] dst;
    logic             we;
    logic             mr;
    logic [1:0]       bt;
  } slot_t;

  // Past EX only the producer/branch fields are ever looked at, so MEM and WB keep just those.
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] dst;
    logic             we;
    logic             mr;
    logic [1:0]       bt;
  } mem_t;

  slot_t            ex_q;
  slot_t            id_slot;
  mem_t             mem_q;
  logic             wb_v;
  logic             wb_we;
  logic [REG_W-1:0] wb_dst;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             cond_met;
  logic             branch;
  logic             luse;
  logic             bubble;

  always_comb begin
    id_slot = '{v: hz.ID_Valid, rs: hz.ID_rs, rt: hz.ID_rt, ur: hz.ID_UsesRs,
                ut: hz.ID_UsesRt, dst: hz.ID_WriteReg, we: hz.ID_RegWre,
                mr: hz.ID_MemRead, bt: hz.ID_BranchType};
  end

  always_comb begin
    cond_met = 1'b0;
    case (mem_q.bt)
      2'b01:   cond_met = hz.MEM_Zero;
      2'b10:   cond_met = !hz.MEM_Zero;
      2'b11:   cond_met = hz.MEM_Sign;
      default: cond_met = 1'b0;
    endcase
    branch = mem_q.v & cond_met;
  end

  always_comb begin
    luse = ex_q.v & ex_q.mr & ex_q.we & (ex_q.dst != '0) & hz.ID_Valid &
           ((hz.ID_UsesRs & (hz.ID_rs == ex_q.dst)) |
            (hz.ID_UsesRt & (hz.ID_rt == ex_q.dst)));
    // A taken branch flushes the dependent instruction anyway, so it wins over the stall.
    bubble = luse & !branch;
  end

  // MEM outranks WB as the younger producer; a load in MEM cannot supply data yet.
  function automatic logic [1:0] fwd_sel(input logic rd, input logic [REG_W-1:0] src,
                                         input mem_t m, input logic w_v, input logic w_we,
                                         input logic [REG_W-1:0] w_dst);
    if (rd && m.v && m.we && !m.mr && (m.dst != '0) && (m.dst == src))
      return 2'b01;
    else if (rd && w_v && w_we && (w_dst != '0) && (w_dst == src))
      return 2'b10;
    return 2'b00;
  endfunction

  assign hz.Branch     = branch;
  assign hz.ControlSrc = bubble;
  assign hz.Stall      = bubble;
  assign hz.ForwardA   = fwd_sel(ex_q.v & ex_q.ur, ex_q.rs, mem_q, wb_v, wb_we, wb_dst);
  assign hz.ForwardB   = fwd_sel(ex_q.v & ex_q.ut, ex_q.rt, mem_q, wb_v, wb_we, wb_dst);
  assign hz.StallCount = stall_cnt;
  assign hz.FlushCount = flush_cnt;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_v      <= 1'b0;
      wb_we     <= 1'b0;
      wb_dst    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      wb_v   <= mem_q.v;
      wb_we  <= mem_q.we;
      wb_dst <= mem_q.dst;
      if (branch) begin
        mem_q <= '0;
        ex_q  <= '0;
        if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end else begin
        mem_q <= '{v: ex_q.v, dst: ex_q.dst, we: ex_q.we, mr: ex_q.mr, bt: ex_q.bt};
        if (bubble) begin
          ex_q <= '0;
          if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
          ex_q <= id_slot;
        end
      end
    end
  end

endmodule
